soc_reset_sequencer: RTL and testbench
======================================

Name: soc_reset_sequencer

Overview:
Sequences reset release for the SoC after the clock wizard locks. Drives separate peripheral and core resets in a fixed order and re-enters reset on lock loss, a debounced push-button request, or an optional watchdog timeout. Records the cause of the most recent reset. Sits in the FPGA top between clk_wiz_0/IBUFDS and Grande_Risco_5_SOC.

Parameters:
- CLOCK_FREQ, 120_000_000: clk frequency in Hz. Documentation only; no logic depends on it.
- STRETCH_CYCLES, 1024: cycles for which reset is held after lock is seen. Must be >= 1.
- PERIPH_TO_CORE_CYCLES, 16: cycles from peripheral release to core release. Must be >= 1.
- DEBOUNCE_CYCLES, 1_200_000: consecutive stable cycles before the button level is accepted.
- WDT_CYCLES, 120_000_000: watchdog timeout in cycles. Used only with the watchdog macro.

Ports:
- clk  in  1  system clock (clk_wiz clk_out1)
- rst  in  1  asynchronous, active-high reset
- pll_locked_i  in  1  clock wizard locked; asynchronous
- button_i  in  1  soft-reset push button, active-high; asynchronous
- wdt_kick_i  in  1  watchdog kick, one-cycle pulse from SoC
- cause_clr_i  in  1  clears cause_o; honoured in RUN only
- periph_rst_n_o  out  1  peripheral reset (UART/GPIO/LED), active-low
- core_rst_n_o  out  1  CPU core/cache reset, active-low
- ready_o  out  1  high only in RUN
- cause_o  out  4  last reset cause, one-hot: [0] rst, [1] lock loss, [2] button, [3] watchdog

Behaviour:
- One clock. rst is asynchronous and active-high.
- On rst:
  - state = WAIT_LOCK
  - periph_rst_n_o = 0, core_rst_n_o = 0, ready_o = 0
  - cause_o = 4'b0001
  - all counters and synchronizer flops = 0
- Synchronization:
  - pll_locked_i and button_i each pass through 2-FF synchronizers.
  - The FSM sees locked_sync one edge after the second flop.
- Debounce:
  - btn_db changes only after the synced button has differed from btn_db for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce restarts the count.
- All outputs are registered and update on the same edge as the state change.
- WAIT_LOCK:
  - Both resets asserted.
  - locked_sync = 1 -> STRETCH, counter = 0.
- STRETCH:
  - Counter increments each cycle.
  - locked_sync = 0 -> WAIT_LOCK, cause_o = 0010.
  - Counter == STRETCH_CYCLES-1 -> PERIPH, periph_rst_n_o = 1, counter = 0.
- PERIPH:
  - locked_sync = 0 -> WAIT_LOCK, both resets asserted, cause_o = 0010.
  - Counter == PERIPH_TO_CORE_CYCLES-1 -> RUN, core_rst_n_o = 1, ready_o = 1.
- RUN: exit events are checked in priority order lock loss > watchdog > button.
  - locked_sync = 0 -> WAIT_LOCK, cause_o = 0010.
  - Watchdog timeout -> WAIT_LOCK, cause_o = 1000.
  - Rising edge of btn_db -> BTN_HOLD, cause_o = 0100.
  - In every exit, both resets are asserted on the exit edge.
- BTN_HOLD:
  - Resets asserted.
  - Stays here while btn_db = 1; btn_db = 0 -> WAIT_LOCK.
  - Lock loss does not change state here; cause stays 0100.
- Latency from power-up / lock: first edge sampling pll_locked_i = 1 is edge 0.
  - periph_rst_n_o rises at edge 2+STRETCH_CYCLES.
  - core_rst_n_o and ready_o rise at edge 2+STRETCH_CYCLES+PERIPH_TO_CORE_CYCLES.
- Lock loss in RUN: first edge sampling 0 is edge 0; resets assert at edge 2.
- A button press outside RUN is ignored. btn_db already high on entry to RUN does not trigger; only a 0->1 edge does.
- cause_o is overwritten only on a reset event. cause_clr_i in RUN sets it to 0000; elsewhere cause_clr_i is ignored.
- rst mid-sequence returns to the reset values immediately and asynchronously.

Optional Feature:
GR5_RSTSEQ_WATCHDOG_EN
- Defined:
  - wdt_cnt increments each RUN cycle.
  - It clears on wdt_kick_i or when not in RUN.
  - wdt_cnt == WDT_CYCLES-1 without a kick fires the timeout on that edge.
  - Kick and terminal count in the same cycle: the kick wins.
- Undefined:
  - No watchdog counter.
  - wdt_kick_i is ignored.
  - cause_o[3] is never set.
  - Ports are unchanged.

Decomposition:
- Package gr5_reset_pkg holds:
  - state_t enum: WAIT_LOCK, STRETCH, PERIPH, RUN, BTN_HOLD
  - cause bit-index localparams CAUSE_RST = 0, CAUSE_LOCK = 1, CAUSE_BTN = 2, CAUSE_WDT = 3
- Sub-module sync_debounce (2-FF sync + debounce counter, parameter DEBOUNCE_CYCLES) is used for button_i.
- pll_locked_i uses a plain 2-FF sync.

Test Plan:
All scenarios use STRETCH_CYCLES=8, PERIPH_TO_CORE_CYCLES=4, DEBOUNCE_CYCLES=5, WDT_CYCLES=20.

- Power-up: rst for 3 cycles, pll_locked_i=1 from edge 0 -> periph_rst_n_o rises at edge 10; core_rst_n_o and ready_o at edge 14; cause_o = 0001.
- Lock glitch in STRETCH: drop pll_locked_i for 3 cycles at edge 5 -> state returns to WAIT_LOCK, cause_o = 0010; after relock, release timing restarts from the relock edge.
- Lock loss in RUN: drop at edge E -> both resets 0 and ready_o = 0 at edge E+2; cause_o = 0010.
- Button: a 3-cycle pulse causes no reset. Hold high 12 cycles -> BTN_HOLD with cause_o = 0100. On release, after debounce, full sequence re-runs: periph release 8+1 edges after entering WAIT_LOCK, given lock stays high.
- Watchdog (macro on): no kick for 20 RUN cycles -> reset with cause_o = 1000. Kick every 15 cycles -> stays in RUN. Kick on the terminal cycle -> no reset.
- cause_clr_i=1 in RUN -> cause_o = 0000 next edge. cause_clr_i asserted during STRETCH -> cause_o unchanged.

Source files
------------

// File: rtl/soc_reset_sequencer_pkg.sv
// gr5_reset_pkg: shared types and constants for the SoC reset sequencer.
//   state_t    : sequencer FSM states
//   CAUSE_*    : bit positions inside the one-hot reset-cause vector
//   cause_bit(): builds a one-hot cause vector from a bit position
package gr5_reset_pkg;

   typedef enum logic [2:0] {
      WAIT_LOCK,
      STRETCH,
      PERIPH,
      RUN,
      BTN_HOLD
   } state_t;

   localparam int CAUSE_RST  = 0;
   localparam int CAUSE_LOCK = 1;
   localparam int CAUSE_BTN  = 2;
   localparam int CAUSE_WDT  = 3;

   function automatic logic [3:0] cause_bit(input int idx);
      return 4'(1) << idx;
   endfunction

endpackage

// File: rtl/soc_reset_sequencer_sync_debounce.sv
// sync_debounce: 2-FF synchronizer followed by a level debouncer.
// The accepted level only follows the synchronized input after it has
// differed from the accepted level for DEBOUNCE_CYCLES consecutive cycles;
// any return to the accepted level restarts the count.
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset (all flops to 0)
//   i_async  in   asynchronous raw input
//   o_level  out  debounced, synchronous level
module sync_debounce
   import gr5_reset_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_200_000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_async,
   output logic o_level
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_meta;
   logic             r_sync;
   logic             r_level;
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta  <= 1'b0;
         r_sync  <= 1'b0;
         r_level <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         if (r_sync == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == TERM) begin
            r_level <= r_sync;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_level = r_level;

endmodule

// File: rtl/soc_reset_sequencer.sv
// soc_reset_sequencer: releases peripheral then core reset after the clock
// wizard locks, and re-enters reset on lock loss, a debounced button press,
// or (optionally) a watchdog timeout. Records the cause of the last reset.
// Optional feature macro: GR5_RSTSEQ_WATCHDOG_EN (watchdog timeout reset).
// Ports:
//   clk             in   system clock
//   rst             in   asynchronous active-high reset
//   pll_locked_i    in   clock wizard locked (asynchronous)
//   button_i        in   soft-reset push button (asynchronous, active-high)
//   wdt_kick_i      in   watchdog kick pulse (used only with the watchdog)
//   cause_clr_i     in   clears cause_o while in RUN
//   periph_rst_n_o  out  peripheral reset, active-low
//   core_rst_n_o    out  CPU core/cache reset, active-low
//   ready_o         out  high only in RUN
//   cause_o         out  one-hot last reset cause {wdt, btn, lock, rst}
module soc_reset_sequencer
   import gr5_reset_pkg::*;
#(
   parameter int CLOCK_FREQ            = 120_000_000,
   parameter int STRETCH_CYCLES        = 1024,
   parameter int PERIPH_TO_CORE_CYCLES = 16,
   parameter int DEBOUNCE_CYCLES       = 1_200_000,
   parameter int WDT_CYCLES            = 120_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pll_locked_i,
   input  logic       button_i,
   input  logic       wdt_kick_i,
   input  logic       cause_clr_i,
   output logic       periph_rst_n_o,
   output logic       core_rst_n_o,
   output logic       ready_o,
   output logic [3:0] cause_o
);

   localparam int SEQ_MAX = (STRETCH_CYCLES > PERIPH_TO_CORE_CYCLES) ?
                            STRETCH_CYCLES : PERIPH_TO_CORE_CYCLES;
   localparam int CNT_W   = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;
   localparam logic [CNT_W-1:0] STRETCH_TERM = CNT_W'(STRETCH_CYCLES - 1);
   localparam logic [CNT_W-1:0] PERIPH_TERM  = CNT_W'(PERIPH_TO_CORE_CYCLES - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [3:0]       r_cause;
   logic [3:0]       w_cause_nxt;
   logic             r_periph_rst_n;
   logic             r_core_rst_n;
   logic             r_ready;
   logic             w_periph_nxt;
   logic             w_core_nxt;
   logic             w_ready_nxt;
   logic             r_lock_meta;
   logic             r_lock_sync;
   logic             w_btn_db;
   logic             r_btn_db_q;
   logic             w_btn_rise;
   logic             w_wdt_fire;
   logic             w_unused;

   // Lock needs no debounce, only a plain 2-FF synchronizer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lock_meta <= 1'b0;
         r_lock_sync <= 1'b0;
      end else begin
         r_lock_meta <= pll_locked_i;
         r_lock_sync <= r_lock_meta;
      end
   end

   sync_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn_db (
      .clk     (clk),
      .rst     (rst),
      .i_async (button_i),
      .o_level (w_btn_db)
   );

   // Only a fresh 0->1 edge counts, so a button already held when RUN is
   // entered does not immediately reset the SoC again.
   assign w_btn_rise = w_btn_db & ~r_btn_db_q;

`ifdef GR5_RSTSEQ_WATCHDOG_EN
   localparam int WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
   localparam logic [WDT_W-1:0] WDT_TERM = WDT_W'(WDT_CYCLES - 1);

   logic [WDT_W-1:0] r_wdt_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wdt_cnt <= '0;
      end else if ((r_state != RUN) || wdt_kick_i) begin
         r_wdt_cnt <= '0;
      end else begin
         r_wdt_cnt <= r_wdt_cnt + 1'b1;
      end
   end

   // A kick on the terminal cycle rescues the SoC.
   assign w_wdt_fire = (r_state == RUN) && !wdt_kick_i && (r_wdt_cnt == WDT_TERM);
   assign w_unused   = &{1'b0, CLOCK_FREQ[0]};
`else
   assign w_wdt_fire = 1'b0;
   assign w_unused   = &{1'b0, CLOCK_FREQ[0], WDT_CYCLES[0], wdt_kick_i};
`endif

   // State register; outputs are registered alongside the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= WAIT_LOCK;
         r_cnt          <= '0;
         r_cause        <= cause_bit(CAUSE_RST);
         r_periph_rst_n <= 1'b0;
         r_core_rst_n   <= 1'b0;
         r_ready        <= 1'b0;
         r_btn_db_q     <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_cnt          <= w_cnt_nxt;
         r_cause        <= w_cause_nxt;
         r_periph_rst_n <= w_periph_nxt;
         r_core_rst_n   <= w_core_nxt;
         r_ready        <= w_ready_nxt;
         r_btn_db_q     <= w_btn_db;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_cause_nxt = r_cause;
      case (r_state)
         WAIT_LOCK: begin
            if (r_lock_sync) begin
               w_state_nxt = STRETCH;
               w_cnt_nxt   = '0;
            end
         end
         STRETCH: begin
            if (!r_lock_sync) begin
               w_state_nxt = WAIT_LOCK;
               w_cause_nxt = cause_bit(CAUSE_LOCK);
            end else if (r_cnt == STRETCH_TERM) begin
               w_state_nxt = PERIPH;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         PERIPH: begin
            if (!r_lock_sync) begin
               w_state_nxt = WAIT_LOCK;
               w_cause_nxt = cause_bit(CAUSE_LOCK);
            end else if (r_cnt == PERIPH_TERM) begin
               w_state_nxt = RUN;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         RUN: begin
            // Exit priority: lock loss, then watchdog, then button.
            if (!r_lock_sync) begin
               w_state_nxt = WAIT_LOCK;
               w_cause_nxt = cause_bit(CAUSE_LOCK);
            end else if (w_wdt_fire) begin
               w_state_nxt = WAIT_LOCK;
               w_cause_nxt = cause_bit(CAUSE_WDT);
            end else if (w_btn_rise) begin
               w_state_nxt = BTN_HOLD;
               w_cause_nxt = cause_bit(CAUSE_BTN);
            end else if (cause_clr_i) begin
               w_cause_nxt = 4'b0000;
            end
         end
         BTN_HOLD: begin
            // Lock loss is deliberately ignored while the button is held.
            if (!w_btn_db) begin
               w_state_nxt = WAIT_LOCK;
            end
         end
         default: begin
            w_state_nxt = WAIT_LOCK;
         end
      endcase
   end

   // Output decode from the next state so outputs change on the state edge.
   always_comb begin
      w_periph_nxt = (w_state_nxt == PERIPH) || (w_state_nxt == RUN);
      w_core_nxt   = (w_state_nxt == RUN);
      w_ready_nxt  = (w_state_nxt == RUN);
   end

   assign periph_rst_n_o = r_periph_rst_n;
   assign core_rst_n_o   = r_core_rst_n;
   assign ready_o        = r_ready;
   assign cause_o        = r_cause;

endmodule

// File: tb/tb_soc_reset_sequencer.sv
// Scoreboard bench for soc_reset_sequencer. The stimulus pushes the expected
// output vector {periph_rst_n, core_rst_n, ready, cause} together with the
// edge number at which it must appear; the monitor pops an entry each time
// the DUT output vector changes and compares both value and edge.
module tb_soc_reset_sequencer;

   localparam int STRETCH = 8;
   localparam int P2C     = 4;
   localparam int DEB     = 5;
   localparam int WDT     = 20;

   logic       clk          = 1'b0;
   logic       rst          = 1'b1;
   logic       pll_locked_i = 1'b0;
   logic       button_i     = 1'b0;
   logic       wdt_kick_i   = 1'b0;
   logic       cause_clr_i  = 1'b0;
   logic       periph_rst_n_o;
   logic       core_rst_n_o;
   logic       ready_o;
   logic [3:0] cause_o;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int         c;
      logic [6:0] v;
   } exp_t;

   exp_t q[$];

   soc_reset_sequencer #(
      .CLOCK_FREQ            (120_000_000),
      .STRETCH_CYCLES        (STRETCH),
      .PERIPH_TO_CORE_CYCLES (P2C),
      .DEBOUNCE_CYCLES       (DEB),
      .WDT_CYCLES            (WDT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .pll_locked_i   (pll_locked_i),
      .button_i       (button_i),
      .wdt_kick_i     (wdt_kick_i),
      .cause_clr_i    (cause_clr_i),
      .periph_rst_n_o (periph_rst_n_o),
      .core_rst_n_o   (core_rst_n_o),
      .ready_o        (ready_o),
      .cause_o        (cause_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [6:0] outs();
      return {periph_rst_n_o, core_rst_n_o, ready_o, cause_o};
   endfunction

   task automatic expect_at(input int c, input logic [6:0] v);
      exp_t e;
      e.c = c;
      e.v = v;
      q.push_back(e);
   endtask

   // Returns at the falling edge once edge n has happened; inputs driven
   // here are first sampled by edge n+1.
   task automatic at(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic kick(input int n);
      at(n);
      wdt_kick_i = 1'b1;
      at(n + 1);
      wdt_kick_i = 1'b0;
   endtask

   task automatic check_now(input string name, input logic [6:0] want);
      checks++;
      if (outs() !== want) begin
         errors++;
         $display("FAIL %s: got %b, want %b", name, outs(), want);
      end
   endtask

   // Monitor: every change of the output vector is one DUT event.
   initial begin : monitor
      logic [6:0] last;
      logic [6:0] cur;
      bit         first;
      exp_t       e;
      first = 1'b1;
      last  = '0;
      forever begin
         @(posedge clk);
         #2;
         cur = outs();
         if (first || cur != last) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event: got %b at edge %0d, want no change", cur, cyc);
            end else begin
               e = q.pop_front();
               if (cur !== e.v || cyc != e.c) begin
                  errors++;
                  $display("FAIL out_event: got %b at edge %0d, want %b at edge %0d",
                           cur, cyc, e.v, e.c);
               end
            end
            first = 1'b0;
            last  = cur;
         end
      end
   end

   initial begin : stimulus
      int h;
      // Reset state, then power-up: lock first sampled at edge 4.
      expect_at(1,  7'b000_0001);
      expect_at(14, 7'b100_0001);
      expect_at(18, 7'b111_0001);
      at(3);
      rst          = 1'b0;
      pll_locked_i = 1'b1;

      // Cause clear in RUN.
      expect_at(23, 7'b111_0000);
      at(22);
      cause_clr_i = 1'b1;
      at(23);
      cause_clr_i = 1'b0;

      // 3-cycle button bounce: no event.
      at(26);
      button_i = 1'b1;
      at(29);
      button_i = 1'b0;

      // 12-cycle press: BTN_HOLD, release, re-sequence with a lock glitch
      // in STRETCH and a cause clear attempt (ignored) in the new STRETCH.
      expect_at(48, 7'b000_0100);
      expect_at(65, 7'b000_0010);
      expect_at(76, 7'b100_0010);
      expect_at(80, 7'b111_0010);
      at(40);
      button_i = 1'b1;
      at(52);
      button_i = 1'b0;
      at(62);
      pll_locked_i = 1'b0;
      at(65);
      pll_locked_i = 1'b1;
      at(70);
      cause_clr_i = 1'b1;
      at(72);
      cause_clr_i = 1'b0;

      // Lock loss in RUN and relock.
      expect_at(93,  7'b000_0010);
      expect_at(106, 7'b100_0010);
      expect_at(110, 7'b111_0010);
      at(90);
      pll_locked_i = 1'b0;
      at(95);
      pll_locked_i = 1'b1;

`ifdef GR5_RSTSEQ_WATCHDOG_EN
      // Timeout with no kicks, periodic kicks, kick on terminal cycle.
      expect_at(130, 7'b000_1000);
      expect_at(139, 7'b100_1000);
      expect_at(143, 7'b111_1000);
      expect_at(243, 7'b000_1000);
      expect_at(252, 7'b100_1000);
      expect_at(256, 7'b111_1000);
      kick(157);
      kick(172);
      kick(187);
      kick(202);
      kick(222);
      h = 260;
`else
      // Without the watchdog, a long kick-free RUN stays quiet.
      h = 150;
`endif

      // Asynchronous reset in RUN, then again while in PERIPH.
      expect_at(h + 1,  7'b000_0001);
      expect_at(h + 13, 7'b100_0001);
      expect_at(h + 15, 7'b000_0001);
      expect_at(h + 27, 7'b100_0001);
      expect_at(h + 31, 7'b111_0001);
      at(h);
      rst = 1'b1;
      #1;
      check_now("async_rst_run", 7'b000_0001);
      at(h + 2);
      rst = 1'b0;
      at(h + 14);
      rst = 1'b1;
      #1;
      check_now("async_rst_periph", 7'b000_0001);
      at(h + 16);
      rst = 1'b0;

      at(h + 36);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL pending_events: got %0d left, want 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
